// File: rtl/rf_warb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
package rf_warb_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 1 << REG_W;

  // "reg" is a keyword, so the destination field is named dest
  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } lu_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } warb_state_t;

  // Register 0 is hardwired, so it never maps to a pending bit
  function automatic logic [NUM_REGS-1:0] onehot32(input logic [REG_W-1:0] r);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (r != '0) v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// WB / LU / RF-write bundle of the register-file write arbiter.
interface rf_write_arbiter_if
  import rf_warb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                in_wb_we;
  logic [REG_W-1:0]    in_wb_reg;
  logic [DATA_W-1:0]   in_wb_data;
  logic                in_lu_valid;
  logic [REG_W-1:0]    in_lu_reg;
  logic [DATA_W-1:0]   in_lu_data;
  logic                out_lu_ready;
  logic                out_write_enable;
  logic [REG_W-1:0]    out_write_reg;
  logic [DATA_W-1:0]   out_write_data;
  logic                out_wb_stall;
  logic [NUM_REGS-1:0] out_pending;
  logic [CNT_W-1:0]    out_fifo_count;

  modport master (
    output in_wb_we, in_wb_reg, in_wb_data, in_lu_valid, in_lu_reg, in_lu_data,
    input  out_lu_ready, out_write_enable, out_write_reg, out_write_data,
           out_wb_stall, out_pending, out_fifo_count
  );

  modport slave (
    input  in_wb_we, in_wb_reg, in_wb_data, in_lu_valid, in_lu_reg, in_lu_data,
    output out_lu_ready, out_write_enable, out_write_reg, out_write_data,
           out_wb_stall, out_pending, out_fifo_count
  );

endinterface

// File: rtl/rf_warb_fifo.sv
// Synchronous LU-result FIFO; exposes every slot plus its valid bit for pending tracking.
module rf_warb_fifo
  import rf_warb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  lu_entry_t              wr_entry,
  input  logic                   pop,
  output lu_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output lu_entry_t [DEPTH-1:0]  entries,
  output logic [DEPTH-1:0]       valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lu_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign entries = mem;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Payload storage needs no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Slot i is live when its distance from the read pointer is below occupancy
  always_comb begin
    logic [PTR_W-1:0] off;
    valid = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_ptr;
      valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between WB (priority) and a buffered LU result stream.
// Optional direct LU bypass on an idle, empty cycle: define RF_WARB_BYPASS_EN.
module rf_write_arbiter
  import rf_warb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  lu_entry_t             lu_in;
  lu_entry_t             head;
  lu_entry_t             grant_entry;
  lu_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  wb_grant;
  logic                  head_grant;
  logic                  bypass;
  logic                  push;
  logic                  grant;
  logic [NUM_REGS-1:0]   pending;

  warb_state_t           state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  stall;
  logic                  we;
  logic [REG_W-1:0]      wreg;
  logic [DATA_W-1:0]     wdata;

  assign lu_in = '{dest: bus.in_lu_reg, data: bus.in_lu_data};

  // Grant selection: WB first, then FIFO head, then (optionally) the live LU result
  always_comb begin
    wb_grant   = bus.in_wb_we && (bus.in_wb_reg != '0);
    head_grant = !wb_grant && !empty;
`ifdef RF_WARB_BYPASS_EN
    bypass     = !wb_grant && empty && bus.in_lu_valid && (bus.in_lu_reg != '0);
`else
    bypass     = 1'b0;
`endif
    push       = bus.in_lu_valid && !full && (bus.in_lu_reg != '0) && !bypass;
    grant      = wb_grant || head_grant || bypass;
    grant_entry = lu_in;
    if (wb_grant)        grant_entry = '{dest: bus.in_wb_reg, data: bus.in_wb_data};
    else if (head_grant) grant_entry = head;
  end

  rf_warb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_entry (lu_in),
    .pop      (head_grant),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .entries  (entries),
    .valid    (valid)
  );

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i]) pending = pending | onehot32(entries[i].dest);
    end
  end

  // Starvation FSM, wait counter and the registered RF write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= NORMAL;
      stall    <= 1'b0;
      wait_cnt <= '0;
      we       <= 1'b0;
      wreg     <= '0;
      wdata    <= '0;
    end else begin
      if (head_grant || empty)                 wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(MAX_WAIT))  wait_cnt <= wait_cnt + WAIT_W'(1);

      case (state)
        NORMAL: begin
          if (!empty && !head_grant && (wait_cnt == WAIT_W'(MAX_WAIT - 1))) begin
            state <= FORCE;
            stall <= 1'b1;
          end
        end
        FORCE: begin
          if (head_grant || empty) begin
            state <= NORMAL;
            stall <= 1'b0;
          end
        end
        default: begin
          state <= NORMAL;
          stall <= 1'b0;
        end
      endcase

      we <= grant;
      if (grant) begin
        wreg  <= grant_entry.dest;
        wdata <= grant_entry.data;
      end
    end
  end

  assign bus.out_lu_ready     = !full;
  assign bus.out_write_enable = we;
  assign bus.out_write_reg    = wreg;
  assign bus.out_write_data   = wdata;
  assign bus.out_wb_stall     = stall;
  assign bus.out_pending      = pending;
  assign bus.out_fifo_count   = count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter (DEPTH=4, MAX_WAIT=8).
module tb_rf_write_arbiter;

  logic clk;
  logic reset;
  int unsigned n_vec;
  int unsigned n_err;

  rf_write_arbiter_if #(.DEPTH(4)) bus ();

  rf_write_arbiter #(
    .DEPTH    (4),
    .MAX_WAIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_wb_we    = 1'b0;
    bus.in_wb_reg   = 5'd0;
    bus.in_wb_data  = 32'h0;
    bus.in_lu_valid = 1'b0;
    bus.in_lu_reg   = 5'd0;
    bus.in_lu_data  = 32'h0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.in_wb_we   = 1'b1;
    bus.in_wb_reg  = r;
    bus.in_wb_data = d;
  endtask

  task automatic lu(input logic [4:0] r, input logic [31:0] d);
    bus.in_lu_valid = 1'b1;
    bus.in_lu_reg   = r;
    bus.in_lu_data  = d;
  endtask

  task automatic check_wr(input string tag, input logic e, input logic [4:0] r, input logic [31:0] d);
    check({tag, "_we"},   32'(bus.out_write_enable), 32'(e));
    check({tag, "_reg"},  32'(bus.out_write_reg),    32'(r));
    check({tag, "_data"}, bus.out_write_data,        d);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset held with active inputs
    reset = 1'b0;
    wb(5'd5, 32'hCAFE_0001);
    lu(5'd7, 32'hCAFE_0002);
    tick();
    tick();
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst_stall",   32'(bus.out_wb_stall),   32'd0);
    check("rst_pending", bus.out_pending,         32'd0);
    check("rst_count",   32'(bus.out_fifo_count), 32'd0);
    idle();
    reset = 1'b1;
    tick();
    check("rst_ready", 32'(bus.out_lu_ready),     32'd1);
    check("rst_we2",   32'(bus.out_write_enable), 32'd0);

    // WB only, then WB to r0 is filtered and outputs hold
    wb(5'd5, 32'hDEAD_BEEF);
    tick();
    check_wr("wb5", 1'b1, 5'd5, 32'hDEAD_BEEF);
    wb(5'd0, 32'h1234);
    tick();
    check_wr("wb0", 1'b0, 5'd5, 32'hDEAD_BEEF);

    // LU drain: first push lands under a WB write, second arrives on an idle WB cycle
    wb(5'd1, 32'hA);
    lu(5'd7, 32'h11);
    tick();
    check_wr("drn_wb", 1'b1, 5'd1, 32'hA);
    check("drn_pend1", bus.out_pending, 32'h0000_0080);
    idle();
    lu(5'd9, 32'h22);
    tick();
    check_wr("drn_7", 1'b1, 5'd7, 32'h11);
    check("drn_pend2", bus.out_pending, 32'h0000_0200);
    idle();
    tick();
    check_wr("drn_9", 1'b1, 5'd9, 32'h22);
    check("drn_pend3", bus.out_pending,         32'h0);
    check("drn_cnt",   32'(bus.out_fifo_count), 32'd0);

    // LU to r0: accepted, never enqueued or written
    lu(5'd0, 32'h55);
    check("r0_ready", 32'(bus.out_lu_ready), 32'd1);
    tick();
    idle();
    check("r0_cnt", 32'(bus.out_fifo_count),   32'd0);
    check("r0_we",  32'(bus.out_write_enable), 32'd0);

    // Fill under busy WB; fifth result waits for ready
    for (int k = 0; k < 4; k++) begin
      wb(5'd2, 32'h100 + 32'(k));
      lu(5'(10 + k), 32'hA0 + 32'(k));
      check("full_rdy", 32'(bus.out_lu_ready), 32'd1);
      tick();
      check("full_wreg", 32'(bus.out_write_reg),  32'd2);
      check("full_cnt",  32'(bus.out_fifo_count), 32'(k + 1));
    end
    wb(5'd2, 32'h104);
    lu(5'd14, 32'hA4);
    check("full_rdy0", 32'(bus.out_lu_ready), 32'd0);
    tick();
    check_wr("full_wb", 1'b1, 5'd2, 32'h104);
    check("full_cnt4", 32'(bus.out_fifo_count), 32'd4);
    check("full_pend", bus.out_pending,         32'h0000_3C00);
    bus.in_wb_we = 1'b0;
    tick();
    check_wr("full_10", 1'b1, 5'd10, 32'hA0);
    check("full_cnt3a", 32'(bus.out_fifo_count), 32'd3);
    check("full_rdy1",  32'(bus.out_lu_ready),   32'd1);
    tick();
    bus.in_lu_valid = 1'b0;
    check_wr("full_11", 1'b1, 5'd11, 32'hA1);
    check("full_cnt3b", 32'(bus.out_fifo_count), 32'd3);
    tick();
    check_wr("full_12", 1'b1, 5'd12, 32'hA2);
    tick();
    check_wr("full_13", 1'b1, 5'd13, 32'hA3);
    check("full_pend14", bus.out_pending, 32'h0000_4000);
    tick();
    check_wr("full_14", 1'b1, 5'd14, 32'hA4);
    check("full_pend0", bus.out_pending, 32'h0);
    idle();
    tick();

    // Starvation: one queued entry, WB writes every cycle
    wb(5'd4, 32'h44);
    lu(5'd20, 32'h2020);
    tick();
    bus.in_lu_valid = 1'b0;
    check("stv_cnt", 32'(bus.out_fifo_count), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("stv_stall", 32'(bus.out_wb_stall), 32'(k == 8));
    end
    tick();
    check("stv_hold",  32'(bus.out_wb_stall),  32'd1);
    check("stv_wbwin", 32'(bus.out_write_reg), 32'd4);
    bus.in_wb_we = 1'b0;
    tick();
    check_wr("stv_head", 1'b1, 5'd20, 32'h2020);
    check("stv_drop", 32'(bus.out_wb_stall),   32'd0);
    check("stv_cnt0", 32'(bus.out_fifo_count), 32'd0);
    idle();
    tick();

    // LU arriving on an idle WB cycle with an empty FIFO
    lu(5'd3, 32'h33);
    tick();
    idle();
`ifdef RF_WARB_BYPASS_EN
    check_wr("byp_1", 1'b1, 5'd3, 32'h33);
    check("byp_pend", bus.out_pending,         32'h0);
    check("byp_cnt",  32'(bus.out_fifo_count), 32'd0);
`else
    check("nobyp_we",   32'(bus.out_write_enable), 32'd0);
    check("nobyp_pend", bus.out_pending,           32'h0000_0008);
    tick();
    check_wr("nobyp_2", 1'b1, 5'd3, 32'h33);
    check("nobyp_pend0", bus.out_pending, 32'h0);
`endif
    tick();

    // Mid-operation reset discards queued results
    wb(5'd2, 32'h77);
    lu(5'd21, 32'h21);
    tick();
    lu(5'd22, 32'h22);
    tick();
    check("mrst_cnt2", 32'(bus.out_fifo_count), 32'd2);
    reset = 1'b0;
    tick();
    check_wr("mrst", 1'b0, 5'd0, 32'h0);
    check("mrst_cnt",  32'(bus.out_fifo_count), 32'd0);
    check("mrst_pend", bus.out_pending,          32'h0);
    idle();
    reset = 1'b1;
    tick();
    check("mrst_we", 32'(bus.out_write_enable), 32'd0);
    tick();
    check("mrst_we2", 32'(bus.out_write_enable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
